interleaver: RTL and testbench

- Bit-serial IEEE 802.11a block interleaver between the convolutional encoder/puncturer and the subcarrier mapper.
- Collects one OFDM symbol of coded bits (NCBPS bits, selected by the 4-bit RATE code) and emits them in the standard two-step permuted order.
- Uses ping-pong buffering, so a continuous input stream yields a continuous output stream delayed by one symbol.

---
 rtl/interleaver.sv | 190 +++++++++++++++++++
 tb/tb_interleaver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver.sv
// Bit-serial IEEE 802.11a block interleaver with ping-pong symbol banks.
// Define INTERLEAVER_STRICT_RATE_EN to refuse symbols whose Rate code is illegal.
module interleaver #(
   parameter int unsigned MAXBITS = 288
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic       x,
   input  logic [3:0] Rate,
   output logic       y,
   output logic       Valid
);

   localparam int unsigned KW = $clog2(MAXBITS);
   localparam int unsigned AW = $clog2(2 * MAXBITS);

   typedef enum logic [1:0] {Mode48, Mode96, Mode192, Mode288} mode_e;

   function automatic logic [KW-1:0] ncbps_of(input mode_e m);
      case (m)
         Mode96:  ncbps_of = KW'(96);
         Mode192: ncbps_of = KW'(192);
         Mode288: ncbps_of = KW'(288);
         default: ncbps_of = KW'(48);
      endcase
   endfunction

   // Column count (NCBPS/16) of the first permutation step.
   function automatic logic [KW-1:0] cols_of(input mode_e m);
      case (m)
         Mode96:  cols_of = KW'(6);
         Mode192: cols_of = KW'(12);
         Mode288: cols_of = KW'(18);
         default: cols_of = KW'(3);
      endcase
   endfunction

   mode_e         rate_mode;
   logic          rate_ok;

   always_comb begin
      rate_mode = Mode48;
      rate_ok   = 1'b1;
      case (Rate)
         4'b1101, 4'b1111: rate_mode = Mode48;
         4'b0101, 4'b0111: rate_mode = Mode96;
         4'b1001, 4'b1011: rate_mode = Mode192;
         4'b0001, 4'b0011: rate_mode = Mode288;
         default: begin
`ifdef INTERLEAVER_STRICT_RATE_EN
            rate_ok = 1'b0;
`else
            rate_ok = 1'b1;
`endif
         end
      endcase
   end

   logic [KW-1:0] k_q, k_d;
   mode_e         mode_q, mode_d;
   logic          fill_bank_q, fill_bank_d;
   mode_e         cur_mode;
   logic          accept;
   logic          sym_done;

   // Rate is only looked at on the first bit; later bits use the latched mode.
   assign cur_mode = (k_q == '0) ? rate_mode : mode_q;
   assign accept   = Start && ((k_q != '0) || rate_ok);

   logic [3:0]    k_lo;
   logic [KW-1:0] k_hi;
   logic [KW-1:0] perm_i;
   logic [KW-1:0] perm_j;
   logic [1:0]    hi_mod3;
   logic [1:0]    lo_mod3;
   logic [2:0]    diff3;
   logic [1:0]    t3;

   // floor(16*i/NCBPS) collapses to k mod 16, and NCBPS mod s is always 0,
   // so the second step only needs (i - k_lo) mod s.
   always_comb begin
      k_lo    = k_q[3:0];
      k_hi    = k_q >> 4;
      perm_i  = cols_of(cur_mode) * {{(KW-4){1'b0}}, k_lo} + k_hi;
      hi_mod3 = 2'(k_hi % KW'(3));
      lo_mod3 = 2'(k_lo % 4'd3);
      diff3   = {1'b0, hi_mod3} + 3'd3 - {1'b0, lo_mod3};
      t3      = (diff3 >= 3'd3) ? 2'(diff3 - 3'd3) : diff3[1:0];
      case (cur_mode)
         Mode192: perm_j = {perm_i[KW-1:1], perm_i[0] ^ k_lo[0]};
         Mode288: perm_j = perm_i - {{(KW-2){1'b0}}, hi_mod3} + {{(KW-2){1'b0}}, t3};
         default: perm_j = perm_i;
      endcase
   end

   always_comb begin
      k_d         = k_q;
      mode_d      = mode_q;
      fill_bank_d = fill_bank_q;
      sym_done    = 1'b0;
      if (accept) begin
         if (k_q == '0) begin
            mode_d = rate_mode;
         end
         if (k_q == ncbps_of(cur_mode) - KW'(1)) begin
            k_d         = '0;
            fill_bank_d = ~fill_bank_q;
            sym_done    = 1'b1;
         end else begin
            k_d = k_q + KW'(1);
         end
      end
   end

   logic          buf_mem [2*MAXBITS];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign wr_ptr = fill_bank_q ? AW'(perm_j) + AW'(MAXBITS) : AW'(perm_j);

   always_ff @(posedge Clk) begin
      if (accept) begin
         buf_mem[wr_ptr] <= x;
      end
   end

   logic          rd_active_q, rd_active_d;
   logic [KW-1:0] rd_addr_q, rd_addr_d;
   logic          rd_bank_q, rd_bank_d;
   mode_e         rd_mode_q, rd_mode_d;
   logic          y_q, y_d;
   logic          valid_q, valid_d;

   assign rd_ptr = rd_bank_q ? AW'(rd_addr_q) + AW'(MAXBITS) : AW'(rd_addr_q);

   always_comb begin
      rd_active_d = rd_active_q;
      rd_addr_d   = rd_addr_q;
      rd_bank_d   = rd_bank_q;
      rd_mode_d   = rd_mode_q;
      y_d         = 1'b0;
      valid_d     = 1'b0;
      if (rd_active_q) begin
         y_d     = buf_mem[rd_ptr];
         valid_d = 1'b1;
         if (rd_addr_q == ncbps_of(rd_mode_q) - KW'(1)) begin
            rd_active_d = 1'b0;
         end else begin
            rd_addr_d = rd_addr_q + KW'(1);
         end
      end
      // A freshly completed bank takes over the read side; in a steady stream this
      // coincides with the last read of the previous bank.
      if (sym_done) begin
         rd_active_d = 1'b1;
         rd_addr_d   = '0;
         rd_bank_d   = fill_bank_q;
         rd_mode_d   = cur_mode;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         k_q         <= '0;
         mode_q      <= Mode48;
         fill_bank_q <= 1'b0;
         rd_active_q <= 1'b0;
         rd_addr_q   <= '0;
         rd_bank_q   <= 1'b0;
         rd_mode_q   <= Mode48;
         y_q         <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         k_q         <= k_d;
         mode_q      <= mode_d;
         fill_bank_q <= fill_bank_d;
         rd_active_q <= rd_active_d;
         rd_addr_q   <= rd_addr_d;
         rd_bank_q   <= rd_bank_d;
         rd_mode_q   <= rd_mode_d;
         y_q         <= y_d;
         valid_q     <= valid_d;
      end
   end

   assign y     = y_q;
   assign Valid = valid_q;

endmodule

// File: tb/tb_interleaver.sv
// Directed, table-driven bench for the 802.11a block interleaver.
module tb_interleaver;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic       x;
   logic [3:0] Rate;
   logic       y;
   logic       Valid;

   int n_checks = 0;
   int n_fail   = 0;

   interleaver #(.MAXBITS(288)) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .Start(Start),
      .x    (x),
      .Rate (Rate),
      .y    (y),
      .Valid(Valid)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [3:0] rate;
      int         n;
      int         hot;
      int         exp_idx;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Direct transcription of the 802.11a two-step permutation.
   function automatic int perm(input int k, input int n, input int bpsc);
      int i;
      int s;
      i = (n / 16) * (k % 16) + k / 16;
      s = (bpsc / 2 > 1) ? bpsc / 2 : 1;
      return s * (i / s) + (i + n - (16 * i) / n) % s;
   endfunction

   function automatic logic [287:0] interleave(input logic [287:0] d, input int n,
                                               input int bpsc);
      logic [287:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r[perm(k, n, bpsc)] = d[k];
      return r;
   endfunction

   // Returns at the negedge just after the edge that accepted the last bit.
   task automatic drive_symbol(input logic [3:0] r, input int n, input logic [287:0] d,
                               input bit toggle);
      for (int k = 0; k < n; k++) begin
         @(negedge Clk);
         Start = 1'b1;
         x     = d[k];
         Rate  = (toggle && k > 0) ? 4'b0001 : r;
         if (toggle && k != n - 1) begin
            @(negedge Clk);
            Start = 1'b0;
            x     = ~d[k];
         end
      end
      @(negedge Clk);
      Start = 1'b0;
      x     = 1'b0;
   endtask

   task automatic collect(input int n, output logic [287:0] bits, output int nval);
      bits = '0;
      nval = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge Clk);
         bits[c] = y;
         if (Valid) nval++;
      end
   endtask

   task automatic check_symbol(input string name, input int n, input logic [287:0] exp,
                               output logic [287:0] got);
      int nval;
      int errs;
      check({name, " latency_low"}, int'(Valid), 0);
      collect(n, got, nval);
      check({name, " valid_count"}, nval, n);
      errs = 0;
      for (int c = 0; c < n; c++) if (got[c] !== exp[c]) errs++;
      check({name, " data_errors"}, errs, 0);
      @(negedge Clk);
      check({name, " tail_low"}, int'(Valid), 0);
   endtask

   initial begin
      vec_t         vecs [11];
      logic [287:0] data;
      logic [287:0] expb;
      logic [287:0] got;
      logic [539:0] sin;
      logic [527:0] sexp;
      int           pos;
      int           nv;
      int           first;
      int           last;
      int           gaps;
      int           derr;

      vecs[0]  = '{4'b1101, 48, 1, 3};
      vecs[1]  = '{4'b1101, 48, 16, 1};
      vecs[2]  = '{4'b1111, 48, 47, 47};
      vecs[3]  = '{4'b1001, 192, 1, 13};
      vecs[4]  = '{4'b1001, 192, 16, 1};
      vecs[5]  = '{4'b0001, 288, 1, 20};
      vecs[6]  = '{4'b0001, 288, 0, 0};
      vecs[7]  = '{4'b0101, 96, 17, 7};
      vecs[8]  = '{4'b0011, 288, 2, 37};
      vecs[9]  = '{4'b1011, 192, 3, 37};
      vecs[10] = '{4'b0000, 48, 1, 3};

      Reset = 1'b0;
      Start = 1'b0;
      x     = 1'b0;
      Rate  = 4'b1101;
      #12;
      check("reset Valid", int'(Valid), 0);
      check("reset y", int'(y), 0);
      @(negedge Clk);
      Reset = 1'b1;

      for (int v = 0; v < 11; v++) begin
         data = '0;
         data[vecs[v].hot] = 1'b1;
         expb = '0;
         expb[vecs[v].exp_idx] = 1'b1;
         drive_symbol(vecs[v].rate, vecs[v].n, data, 1'b0);
         check_symbol($sformatf("vec%0d", v), vecs[v].n, expb, got);
         pos = -1;
         for (int c = 0; c < vecs[v].n; c++) if (got[c] === 1'b1 && pos < 0) pos = c;
         check($sformatf("vec%0d one_position", v), pos, vecs[v].exp_idx);
      end

      // Start toggles every cycle; Rate is changed mid-symbol and must be ignored.
      data = '0;
      for (int k = 0; k < 48; k++) data[k] = 1'($urandom_range(0, 1));
      drive_symbol(4'b1101, 48, data, 1'b1);
      check_symbol("toggle", 48, interleave(data, 48, 1), got);

      // Reset during readout.
      data = '0;
      for (int k = 0; k < 48; k++) data[k] = 1'b1;
      drive_symbol(4'b1101, 48, data, 1'b0);
      repeat (10) @(negedge Clk);
      check("readout Valid before reset", int'(Valid), 1);
      check("readout y before reset", int'(y), 1);
      #2 Reset = 1'b0;
      #1;
      check("reset mid-readout Valid", int'(Valid), 0);
      check("reset mid-readout y", int'(y), 0);
      @(negedge Clk);
      Reset = 1'b1;
      collect(60, got, nv);
      check("aborted readout valid_count", nv, 0);

      // Reset during a partial symbol, then a full symbol must start at k=0.
      for (int k = 0; k < 20; k++) begin
         @(negedge Clk);
         Start = 1'b1;
         Rate  = 4'b1101;
         x     = 1'b1;
      end
      @(negedge Clk);
      Start = 1'b0;
      x     = 1'b0;
      #2 Reset = 1'b0;
      #1;
      check("reset mid-symbol Valid", int'(Valid), 0);
      @(negedge Clk);
      Reset = 1'b1;
      data = '0;
      for (int k = 0; k < 48; k++) data[k] = 1'($urandom_range(0, 1));
      drive_symbol(4'b1101, 48, data, 1'b0);
      check_symbol("post_reset", 48, interleave(data, 48, 1), got);

      // 540-bit continuous stream: 11 full symbols plus a 12-bit tail.
      for (int c = 0; c < 540; c++) sin[c] = 1'($urandom_range(0, 1));
      for (int s = 0; s < 11; s++)
         for (int k = 0; k < 48; k++) sexp[48 * s + perm(k, 48, 1)] = sin[48 * s + k];
      first = -1;
      last  = -1;
      nv    = 0;
      gaps  = 0;
      derr  = 0;
      fork
         begin
            for (int c = 0; c < 540; c++) begin
               @(negedge Clk);
               Start = 1'b1;
               Rate  = 4'b1101;
               x     = sin[c];
            end
            @(negedge Clk);
            Start = 1'b0;
            x     = 1'b0;
         end
         begin
            for (int c = 0; c < 620; c++) begin
               @(negedge Clk);
               if (Valid) begin
                  if (first < 0) first = c;
                  else if (c != last + 1) gaps++;
                  if (nv < 528 && y !== sexp[nv]) derr++;
                  nv++;
                  last = c;
               end
            end
         end
      join
      check("stream first_valid_cycle", first, 49);
      check("stream valid_count", nv, 528);
      check("stream gaps", gaps, 0);
      check("stream data_errors", derr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
